// File: rtl/agc_fetch_pkg.sv
// Shared types for the AGC instruction fetch path: word geometry, fetch FSM
// states and the buffered entry layout.
package agc_fetch_pkg;

  localparam int AGC_WORD_W = 16;
  localparam int AGC_DATA_W = 15;
  localparam int AGC_ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [AGC_DATA_W-1:0] data;
    logic [AGC_ADDR_W-1:0] addr;
    logic                  perr;
  } fetch_entry_t;

  // Odd parity: a good word has an odd number of ones across all 16 bits.
  function automatic logic parity_err(input logic [AGC_WORD_W-1:0] word);
    return ~^word;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry synchronous FIFO with push/pop/clear and an occupancy
// count; the head entry is read straight from registered storage.
module fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Clear wins over any same-cycle push or pop; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues one memory read at a time from the PC stream,
// parity-checks the returned AGC word and buffers it for decode.
//
// state | meaning
// IDLE  | no request outstanding; may issue when a FIFO slot is free
// WAIT  | one request outstanding; its response will be buffered
// DROP  | one request outstanding; its response is discarded (flushed)
module instr_fetch
  import agc_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 12,
  parameter int WW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_addr,
  output logic          pc_enable,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rvalid,
  input  logic [WW-1:0] mem_rdata,
  input  logic          flush,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [WW-2:0] instr_word,
  output logic [AW-1:0] instr_addr,
  output logic          instr_perr
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_n;
  logic [CW-1:0] count;
  logic [AW-1:0] req_addr;
  logic          issue;
  logic          push;
  logic          pop;
  logic          empty;
  fetch_entry_t  din;
  fetch_entry_t  head;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Issue uses the registered count, so a pop while full lets the next
  // issue happen one cycle later rather than combinationally.
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    push    = 1'b0;
    unique case (state)
      IDLE: begin
        issue = (count < CW'(DEPTH)) && !flush && !reset;
        if (issue) state_n = WAIT;
      end
      WAIT: begin
        push = mem_rvalid && !flush;
        if (mem_rvalid)  state_n = IDLE;
        else if (flush)  state_n = DROP;
      end
      DROP: begin
        if (mem_rvalid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign mem_read  = issue;
  assign pc_enable = issue;
  assign mem_addr  = issue ? pc_addr : '0;

  always_ff @(posedge clk) begin
    if (reset)      req_addr <= '0;
    else if (issue) req_addr <= pc_addr;
  end

  assign pop = instr_valid && instr_ready;
  assign din = '{data: mem_rdata[WW-2:0], addr: req_addr, perr: parity_err(mem_rdata)};

  fetch_fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .empty (empty)
  );

  assign instr_valid = !empty;
  assign instr_word  = head.data;
  assign instr_addr  = head.addr;
  assign instr_perr  = head.perr;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural memory + PC, scoreboard of expected
// decode-side words, parity vector table and directed flush/reset sequences.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pc_addr;
  logic        pc_enable;
  logic        mem_read;
  logic [11:0] mem_addr;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic [14:0] instr_word;
  logic [11:0] instr_addr;
  logic        instr_perr;

  always #5 clk = ~clk;

  instr_fetch #(.DEPTH(2), .AW(12), .WW(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_addr     (pc_addr),
    .pc_enable   (pc_enable),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .flush       (flush),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_word  (instr_word),
    .instr_addr  (instr_addr),
    .instr_perr  (instr_perr)
  );

  typedef struct packed {
    logic [14:0] word;
    logic [11:0] addr;
    logic        perr;
  } exp_t;

  typedef struct {
    logic [11:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] rdata;
    logic [14:0] word;
    logic        perr;
  } vec_t;

  exp_t        exp_q[$];
  pend_t       mem_pend[$];
  logic [11:0] issue_log[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  bit          outstanding = 0;
  bit          dropping = 0;
  bit          rforce_en = 0;
  logic [15:0] rforce_val = '0;
  vec_t        vecs[8];

  // Default memory contents always carry correct odd parity.
  function automatic logic [15:0] mem_word(input logic [11:0] a);
    logic [14:0] d;
    d = {3'b010, a} ^ 15'h2a5c;
    return {~^d, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive memory response, sample at negedge+1, update models,
  // return on the next negedge with the PC advanced if it was enabled.
  task automatic tick();
    pend_t       p;
    logic [11:0] resp_addr;
    bit          pc_inc;
    resp_addr  = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (mem_pend.size() != 0 && mem_pend[0].due == cyc) begin
      p          = mem_pend.pop_front();
      resp_addr  = p.addr;
      mem_rvalid = 1'b1;
      mem_rdata  = rforce_en ? rforce_val : mem_word(p.addr);
      rforce_en  = 0;
    end
    #1;
    if (reset) begin
      chk("rst_mem_read", mem_read, 0);
      chk("rst_pc_enable", pc_enable, 0);
    end
    chk("pc_enable_vs_read", pc_enable, mem_read);
    if (mem_read) chk("mem_addr", mem_addr, pc_addr);
    chk("instr_valid", instr_valid, exp_q.size() != 0);
    if (instr_valid && exp_q.size() != 0) begin
      chk("head_word", instr_word, exp_q[0].word);
      chk("head_addr", instr_addr, exp_q[0].addr);
      chk("head_perr", instr_perr, exp_q[0].perr);
      if (instr_ready) void'(exp_q.pop_front());
    end
    if (reset) begin
      exp_q.delete();
      outstanding = 0;
      dropping    = 0;
    end else begin
      if (mem_rvalid && outstanding) begin
        if (!flush && !dropping)
          exp_q.push_back('{word: mem_rdata[14:0], addr: resp_addr, perr: ~^mem_rdata});
        outstanding = 0;
        dropping    = 0;
      end
      if (flush) begin
        exp_q.delete();
        if (outstanding) dropping = 1;
      end
      if (mem_read) begin
        outstanding = 1;
        mem_pend.push_back('{addr: pc_addr, due: cyc + mem_lat});
        issue_log.push_back(pc_addr);
      end
    end
    pc_inc = pc_enable;
    @(negedge clk);
    cyc++;
    if (pc_inc) pc_addr = pc_addr + 12'd1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    flush       = 1'b0;
    instr_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    mem_pend.delete();
    mem_lat = 1;
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_word", instr_word, 0);
    chk("rst_instr_addr", instr_addr, 0);
    chk("rst_instr_perr", instr_perr, 0);
  endtask

  task automatic drain();
    instr_ready = 1'b1;
    repeat (10) tick();
    instr_ready = 1'b0;
  endtask

  int n0;

  initial begin
    vecs[0] = '{12'h020, 16'h0000, 15'h0000, 1'b1};
    vecs[1] = '{12'h021, 16'h8000, 15'h0000, 1'b0};
    vecs[2] = '{12'h022, 16'h0003, 15'h0003, 1'b1};
    vecs[3] = '{12'h023, 16'h8003, 15'h0003, 1'b0};
    vecs[4] = '{12'h024, 16'h7fff, 15'h7fff, 1'b0};
    vecs[5] = '{12'h025, 16'hffff, 15'h7fff, 1'b1};
    vecs[6] = '{12'h026, 16'h4001, 15'h4001, 1'b1};
    vecs[7] = '{12'h027, 16'hc001, 15'h4001, 1'b0};

    reset       = 1'b1;
    flush       = 1'b0;
    instr_ready = 1'b0;
    pc_addr     = '0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    @(negedge clk);

    // Basic latency: issue in cycle 0, word visible in cycle 2.
    do_reset();
    pc_addr = 12'h000;
    n0 = issue_log.size();
    tick();
    chk("lat_issue_c0", issue_log.size() - n0, 1);
    chk("lat_issue_addr", issue_log[n0], 12'h000);
    chk("lat_valid_c1", instr_valid, 0);
    tick();
    chk("lat_valid_c2", instr_valid, 1);
    chk("lat_word", instr_word, 15'h0a5c);
    chk("lat_addr", instr_addr, 12'h000);
    chk("lat_perr", instr_perr, 0);
    drain();

    // Backpressure: exactly DEPTH issues, then one more per pop.
    do_reset();
    pc_addr = 12'h010;
    n0 = issue_log.size();
    repeat (8) tick();
    chk("bp_issue_count", issue_log.size() - n0, 2);
    chk("bp_addr0", issue_log[n0], 12'h010);
    chk("bp_addr1", issue_log[n0+1], 12'h011);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    repeat (6) tick();
    chk("bp_issue_after_pop", issue_log.size() - n0, 3);
    chk("bp_addr2", issue_log[n0+2], 12'h012);
    drain();

    // Parity vectors.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      pc_addr    = vecs[i].addr;
      rforce_en  = 1;
      rforce_val = vecs[i].rdata;
      tick();
      tick();
      chk("par_valid", instr_valid, 1);
      chk("par_word", instr_word, vecs[i].word);
      chk("par_addr", instr_addr, vecs[i].addr);
      chk("par_perr", instr_perr, vecs[i].perr);
    end
    drain();

    // Flush with one word buffered and a slow response outstanding.
    do_reset();
    pc_addr = 12'h100;
    tick();
    tick();
    mem_lat = 3;
    tick();
    chk("fl_pre_valid", instr_valid, 1);
    n0 = issue_log.size();
    flush = 1'b1;
    tick();
    flush   = 1'b0;
    pc_addr = 12'h200;
    chk("fl_valid_after", instr_valid, 0);
    chk("fl_no_issue_flush", issue_log.size() - n0, 0);
    mem_lat = 1;
    tick();
    tick();
    chk("fl_no_issue_drop", issue_log.size() - n0, 0);
    chk("fl_valid_drop", instr_valid, 0);
    tick();
    chk("fl_reissue", issue_log.size() - n0, 1);
    chk("fl_reissue_addr", issue_log[n0], 12'h200);
    drain();

    // Flush coinciding with a response and a pop.
    do_reset();
    pc_addr = 12'h300;
    repeat (3) tick();
    chk("fc_pre_valid", instr_valid, 1);
    n0 = issue_log.size();
    flush       = 1'b1;
    instr_ready = 1'b1;
    tick();
    flush       = 1'b0;
    instr_ready = 1'b0;
    chk("fc_no_pc_enable", issue_log.size() - n0, 0);
    chk("fc_valid_after", instr_valid, 0);
    tick();
    chk("fc_issue_next", issue_log.size() - n0, 1);
    chk("fc_issue_addr", issue_log[n0], 12'h302);
    chk("fc_still_empty", instr_valid, 0);
    drain();

    // Reset while WAIT; the stale response lands the cycle after reset.
    do_reset();
    pc_addr = 12'h040;
    mem_lat = 2;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n0 = issue_log.size();
    tick();
    chk("rw_fresh_issue", issue_log.size() - n0, 1);
    chk("rw_issue_addr", issue_log[n0], 12'h041);
    chk("rw_valid_c2", instr_valid, 0);
    tick();
    chk("rw_valid_c3", instr_valid, 0);
    tick();
    chk("rw_valid_new", instr_valid, 1);
    chk("rw_addr_new", instr_addr, 12'h041);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
